// File: rtl/mem_port_arbiter_if.sv
// Bundle of the shared memory-port signals: IF and MEM requester handshakes,
// the unified memory port, and the acks/read data returned to the pipeline.
// The arbiter takes the slave view; the pipeline/memory side takes the master view.
interface mem_port_arbiter_if;
  // IF stage request
  logic        if_req_i;
  logic [31:0] if_addr_i;
  // MEM stage request
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  // memory side
  logic [31:0] port_rdata_i;
  logic        sel_o;
  logic        port_en_o;
  logic        port_we_o;
  logic [3:0]  port_be_o;
  logic [31:0] port_addr_o;
  logic [31:0] port_wdata_o;
  // completion back to the stages
  logic        if_ack_o;
  logic        mem_ack_o;
  logic [31:0] rdata_o;
  logic        busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
    input  port_rdata_i,
    output sel_o, port_en_o, port_we_o, port_be_o, port_addr_o, port_wdata_o,
    output if_ack_o, mem_ack_o, rdata_o, busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
    output port_rdata_i,
    input  sel_o, port_en_o, port_we_o, port_be_o, port_addr_o, port_wdata_o,
    input  if_ack_o, mem_ack_o, rdata_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter between IF (fetch) and MEM (load/store).
// IDLE -> ACCESS (WAIT_CYCLES cycles, port enabled) -> RESP (one-cycle ack) -> IDLE.
// MEM normally wins; after STARVE_LIMIT consecutive MEM grants with IF waiting,
// IF is forced through. The winning request is latched at the grant edge so
// requester inputs may change freely while the access is in flight.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES - 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // latched copy of the granted access
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  state_t           state, state_nxt;
  logic             sel_q;
  acc_t             acc_q;
  acc_t             grant_acc;
  logic [WCW-1:0]   wait_cnt;
  logic [SCW-1:0]   starve_cnt;
  logic [31:0]      rdata_q;

  logic             req_any;
  logic             if_forced;
  logic             grant_mem;
  logic             grant;
  logic             wait_done;
  logic             in_access;
  logic             is_store;

  assign req_any   = bus.if_req_i | bus.mem_req_i;
  assign if_forced = bus.if_req_i && (starve_cnt == STARVE_MAX);
  assign grant_mem = bus.mem_req_i && !if_forced;
  assign grant     = (state == S_IDLE) && req_any;
  assign wait_done = (wait_cnt == '0);
  assign in_access = (state == S_ACCESS);
  assign is_store  = sel_q && acc_q.we;

  // Winner's access fields; a fetch is always a full-word read.
  always_comb begin
    grant_acc = '0;
    if (grant_mem) begin
      grant_acc.we    = bus.mem_we_i;
      grant_acc.be    = bus.mem_be_i;
      grant_acc.addr  = bus.mem_addr_i;
      grant_acc.wdata = bus.mem_wdata_i;
    end else begin
      grant_acc.we    = 1'b0;
      grant_acc.be    = 4'hF;
      grant_acc.addr  = bus.if_addr_i;
      grant_acc.wdata = '0;
    end
  end

  // State register; reset aborts any access in flight without an ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_any) state_nxt = S_ACCESS;
      S_ACCESS: if (wait_done) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Grant-time latching of owner/access and the access latency counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q    <= 1'b0;
      acc_q    <= '0;
      wait_cnt <= '0;
    end else if (grant) begin
      sel_q    <= grant_mem;
      acc_q    <= grant_acc;
      wait_cnt <= WAIT_LOAD;
    end else if (in_access && !wait_done) begin
      wait_cnt <= wait_cnt - WCW'(1);
    end
  end

  // Starvation counter: counts MEM grants that overtook a waiting fetch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (grant_mem && bus.if_req_i) begin
        if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SCW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Read data captured on the last access cycle; stores leave it untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              rdata_q <= '0;
    else if (in_access && wait_done && !is_store) rdata_q <= bus.port_rdata_i;
  end

  // Port outputs decode from registered state and are quiet outside ACCESS.
  assign bus.sel_o        = sel_q;
  assign bus.port_en_o    = in_access;
  assign bus.port_we_o    = in_access && is_store;
  assign bus.port_be_o    = in_access ? acc_q.be    : 4'h0;
  assign bus.port_addr_o  = in_access ? acc_q.addr  : 32'h0;
  assign bus.port_wdata_o = in_access ? acc_q.wdata : 32'h0;
  assign bus.if_ack_o     = (state == S_RESP) && !sel_q;
  assign bus.mem_ack_o    = (state == S_RESP) &&  sel_q;
  assign bus.rdata_o      = rdata_q;
  assign bus.busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: default build plus WAIT_CYCLES=1/4 builds.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if b0 ();
  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b4 ();

  mem_port_arbiter #(.WAIT_CYCLES(2), .STARVE_LIMIT(3)) u_dut (.clk_i(clk), .rst_i(rst), .bus(b0));
  mem_port_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(3)) u_w1  (.clk_i(clk), .rst_i(rst), .bus(b1));
  mem_port_arbiter #(.WAIT_CYCLES(4), .STARVE_LIMIT(3)) u_w4  (.clk_i(clk), .rst_i(rst), .bus(b4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for an ack on the default build; lands on the ack's negedge.
  task automatic wait_ack(input string tag, output int cyc, output logic is_mem);
    cyc = 0;
    is_mem = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (b0.if_ack_o || b0.mem_ack_o) begin
        cyc = i;
        is_mem = b0.mem_ack_o;
        checks++;
        assert (!(b0.if_ack_o && b0.mem_ack_o)) else begin
          errors++;
          $error("FAIL %s_both_acks observed=1 expected=0", tag);
        end
        return;
      end
    end
    checks++;
    errors++;
    $error("FAIL %s_timeout observed=no_ack expected=ack", tag);
  endtask

  int   cyc;
  logic is_mem;
  logic [4:0] order;

  initial begin
    rst = 1'b1;
    b0.if_req_i = 0; b0.if_addr_i = 0; b0.mem_req_i = 0; b0.mem_we_i = 0;
    b0.mem_be_i = 0; b0.mem_addr_i = 0; b0.mem_wdata_i = 0; b0.port_rdata_i = 0;
    b1.if_req_i = 0; b1.if_addr_i = 0; b1.mem_req_i = 0; b1.mem_we_i = 0;
    b1.mem_be_i = 0; b1.mem_addr_i = 0; b1.mem_wdata_i = 0; b1.port_rdata_i = 0;
    b4.if_req_i = 0; b4.if_addr_i = 0; b4.mem_req_i = 0; b4.mem_we_i = 0;
    b4.mem_be_i = 0; b4.mem_addr_i = 0; b4.mem_wdata_i = 0; b4.port_rdata_i = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {26'd0, b0.sel_o, b0.port_en_o, b0.port_we_o, b0.if_ack_o, b0.mem_ack_o, b0.busy_o}, 32'd0);
    chk("rst_rdata", b0.rdata_o, 32'd0);
    chk("rst_addr", b0.port_addr_o, 32'd0);
    chk("rst_be", {28'd0, b0.port_be_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1: lone fetch
    b0.if_req_i = 1; b0.if_addr_i = 32'h100; b0.port_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_sel", b0.sel_o, 0);
    chk("t1_en1", b0.port_en_o, 1);
    chk("t1_addr", b0.port_addr_o, 32'h100);
    chk("t1_be", b0.port_be_o, 4'hF);
    chk("t1_we", b0.port_we_o, 0);
    @(negedge clk);
    chk("t1_en2", b0.port_en_o, 1);
    chk("t1_early_ack", {b0.if_ack_o, b0.mem_ack_o}, 0);
    @(negedge clk);
    chk("t1_en_off", b0.port_en_o, 0);
    chk("t1_ifack", b0.if_ack_o, 1);
    chk("t1_memack", b0.mem_ack_o, 0);
    chk("t1_rdata", b0.rdata_o, 32'hDEADBEEF);
    b0.if_req_i = 0;
    @(negedge clk);
    chk("t1_ack_pulse", b0.if_ack_o, 0);
    chk("t1_idle", b0.busy_o, 0);

    // T2: store
    b0.mem_req_i = 1; b0.mem_we_i = 1; b0.mem_be_i = 4'b0011;
    b0.mem_addr_i = 32'h2000; b0.mem_wdata_i = 32'h12345678; b0.port_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("t2_sel", b0.sel_o, 1);
    chk("t2_we1", b0.port_we_o, 1);
    chk("t2_be1", b0.port_be_o, 4'b0011);
    chk("t2_addr", b0.port_addr_o, 32'h2000);
    chk("t2_wdata", b0.port_wdata_o, 32'h12345678);
    @(negedge clk);
    chk("t2_we2", b0.port_we_o, 1);
    chk("t2_be2", b0.port_be_o, 4'b0011);
    @(negedge clk);
    chk("t2_memack", b0.mem_ack_o, 1);
    chk("t2_ifack", b0.if_ack_o, 0);
    chk("t2_en_off", b0.port_en_o, 0);
    chk("t2_rdata_hold", b0.rdata_o, 32'hDEADBEEF);
    b0.mem_req_i = 0; b0.mem_we_i = 0;
    @(negedge clk);
    chk("t2_idle", b0.busy_o, 0);

    // T3: simultaneous requests, MEM first then IF
    b0.mem_req_i = 1; b0.mem_we_i = 0; b0.mem_be_i = 4'hF; b0.mem_addr_i = 32'h3000;
    b0.if_req_i = 1; b0.if_addr_i = 32'h104; b0.port_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    chk("t3_sel_mem", b0.sel_o, 1);
    chk("t3_addr_mem", b0.port_addr_o, 32'h3000);
    wait_ack("t3_mem", cyc, is_mem);
    chk("t3_mem_lat", cyc, 2);
    chk("t3_mem_first", is_mem, 1);
    chk("t3_mem_rdata", b0.rdata_o, 32'h0BADF00D);
    b0.mem_req_i = 0; b0.port_rdata_i = 32'h600DCAFE;
    @(negedge clk);
    chk("t3_gap_idle", b0.busy_o, 0);
    chk("t3_sel_hold", b0.sel_o, 1);
    @(negedge clk);
    chk("t3_sel_if", b0.sel_o, 0);
    chk("t3_addr_if", b0.port_addr_o, 32'h104);
    wait_ack("t3_if", cyc, is_mem);
    chk("t3_if_lat", cyc, 2);
    chk("t3_if_second", is_mem, 0);
    chk("t3_if_rdata", b0.rdata_o, 32'h600DCAFE);
    b0.if_req_i = 0;
    @(negedge clk);

    // T4: starvation guard, expect MEM,MEM,MEM,IF,MEM
    b0.mem_req_i = 1; b0.mem_addr_i = 32'h5000; b0.if_req_i = 1; b0.if_addr_i = 32'h200;
    order = '0;
    for (int g = 0; g < 5; g++) begin
      wait_ack("t4_grant", cyc, is_mem);
      order[g] = is_mem;
      if (g == 2) chk("t4_starve_sat", u_dut.starve_cnt, 3);
      if (!is_mem) begin
        b0.if_req_i = 0;
        chk("t4_starve_clr", u_dut.starve_cnt, 0);
      end
    end
    chk("t4_order", order, 5'b10111);
    b0.mem_req_i = 0;
    @(negedge clk);
    chk("t4_idle", b0.busy_o, 0);

    // T5: reset in the second ACCESS cycle
    b0.mem_req_i = 1; b0.mem_addr_i = 32'h4000; b0.if_req_i = 1; b0.if_addr_i = 32'h108;
    @(negedge clk);
    chk("t5_sel_mem", b0.sel_o, 1);
    @(negedge clk);
    chk("t5_en_pre", b0.port_en_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_ctrl", {26'd0, b0.sel_o, b0.port_en_o, b0.port_we_o, b0.if_ack_o, b0.mem_ack_o, b0.busy_o}, 32'd0);
    chk("t5_async_addr", b0.port_addr_o, 32'd0);
    b0.mem_req_i = 0;
    @(negedge clk);
    chk("t5_no_ack", {b0.if_ack_o, b0.mem_ack_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_if_sel", b0.sel_o, 0);
    chk("t5_if_en", b0.port_en_o, 1);
    chk("t5_if_addr", b0.port_addr_o, 32'h108);
    wait_ack("t5_if", cyc, is_mem);
    chk("t5_if_lat", cyc, 2);
    chk("t5_if_ack", is_mem, 0);
    b0.if_req_i = 0;
    @(negedge clk);

    // T6: WAIT_CYCLES=1 and 4 loads, inputs toggled mid-access
    b1.mem_req_i = 1; b1.mem_we_i = 0; b1.mem_be_i = 4'hF; b1.mem_addr_i = 32'h7000;
    b1.mem_wdata_i = 32'hAAAA; b1.port_rdata_i = 32'h11111111;
    b4.mem_req_i = 1; b4.mem_we_i = 0; b4.mem_be_i = 4'hF; b4.mem_addr_i = 32'h7000;
    b4.mem_wdata_i = 32'hAAAA; b4.port_rdata_i = 32'hFFFF0000;
    @(negedge clk);
    chk("t6_w1_en", b1.port_en_o, 1);
    chk("t6_w1_addr", b1.port_addr_o, 32'h7000);
    chk("t6_w4_en1", b4.port_en_o, 1);
    b1.mem_addr_i = 32'h9999; b1.mem_wdata_i = 32'h5555; b1.mem_we_i = 1;
    b4.mem_addr_i = 32'h9999; b4.mem_wdata_i = 32'h5555; b4.mem_we_i = 1;
    @(negedge clk);
    chk("t6_w1_ack", b1.mem_ack_o, 1);
    chk("t6_w1_en_off", b1.port_en_o, 0);
    chk("t6_w1_rdata", b1.rdata_o, 32'h11111111);
    chk("t6_w4_en2", b4.port_en_o, 1);
    chk("t6_w4_addr2", b4.port_addr_o, 32'h7000);
    chk("t6_w4_wdata2", b4.port_wdata_o, 32'hAAAA);
    chk("t6_w4_we2", b4.port_we_o, 0);
    b1.mem_req_i = 0;
    @(negedge clk);
    chk("t6_w1_idle", b1.busy_o, 0);
    chk("t6_w4_en3", b4.port_en_o, 1);
    chk("t6_w4_addr3", b4.port_addr_o, 32'h7000);
    chk("t6_w4_noack3", b4.mem_ack_o, 0);
    @(negedge clk);
    chk("t6_w4_en4", b4.port_en_o, 1);
    chk("t6_w4_noack4", b4.mem_ack_o, 0);
    b4.port_rdata_i = 32'h44444444;
    @(negedge clk);
    chk("t6_w4_ack", b4.mem_ack_o, 1);
    chk("t6_w4_en_off", b4.port_en_o, 0);
    chk("t6_w4_rdata", b4.rdata_o, 32'h44444444);
    b4.mem_req_i = 0;
    @(negedge clk);
    chk("t6_w4_idle", b4.busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
